// File: rtl/fp_addsub_except_pipe_if.sv
// Operand/result bus for fp_addsub_except_pipe.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1 (in_valid/in_ready on the operand side, out_valid/out_ready on
// the result side). A producer holds its payload stable while valid is high
// and ready is low. The consumer's ready may depend combinationally on state.
// The slave modport is the block itself; the master modport is its
// environment: the upstream operand source and the downstream result sink.
interface fp_addsub_except_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    // operand side
    logic          in_valid;
    logic          in_ready;
    logic          sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    // result side
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    op;
    logic [1:0]    exc;
    logic          res_zero;
    logic          invalid;
    logic [W-1:0]  special_res;

    // sticky invalid flag
    logic          flag_clr;
    logic          flag_invalid;

    modport slave (
        input  in_valid, sel, a, b, out_ready, flag_clr,
        output in_ready, out_valid, op, exc, res_zero, invalid, special_res,
               flag_invalid
    );

    modport master (
        output in_valid, sel, a, b, out_ready, flag_clr,
        input  in_ready, out_valid, op, exc, res_zero, invalid, special_res,
               flag_invalid
    );
endinterface

// File: rtl/fp_addsub_except_pipe.sv
// fp_addsub_except_pipe: two-stage special-operand classifier and exception
// resolver for an FP add/sub datapath of width 1+EXP_W+MAN_W.
// Stage 1 registers the operand classes and effective signs; stage 2 registers
// the resolved exception code, invalid bit and canonical special result.
// Optional feature macro: FP_EXC_STICKY_EN enables the sticky invalid flag
// (flag_invalid / flag_clr). Without it flag_invalid is tied to 0.
module fp_addsub_except_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_addsub_except_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    // operand classes
    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    // exception codes
    localparam logic [1:0] EXC_NUM  = 2'b00;
    localparam logic [1:0] EXC_INF  = 2'b01;
    localparam logic [1:0] EXC_NINF = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    // canonical quiet NaN: sign 0, exponent all-ones, only mantissa MSB set
    localparam logic [W-1:0] QNAN_VAL = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [2:0] classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic [2:0]       c;
        e = x[W-2 -: EXP_W];
        m = x[MAN_W-1:0];
        if (e == '0) begin
            c = (m == '0) ? CLS_ZERO : CLS_SUB;
        end else if (e == '1) begin
            if (m == '0)
                c = CLS_INF;
            else if (m[MAN_W-1])
                c = CLS_QNAN;
            else
                c = CLS_SNAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    function automatic logic [W-1:0] inf_val(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    // ---------------- stage 1 state ----------------
    logic       v1;
    logic [2:0] cls_a_q;
    logic [2:0] cls_b_q;
    logic       sign_a_q;
    logic       sign_b_q;

    // ---------------- stage 2 state ----------------
    logic         v2;
    logic [1:0]   op_q;
    logic [1:0]   exc_q;
    logic         res_zero_q;
    logic         invalid_q;
    logic [W-1:0] special_res_q;

    // Stage 1 may take a new pair when it is empty or its content moves on;
    // stage 2 loads when stage 1 holds a pair and stage 2 is empty or draining.
    logic load1;
    logic load2;

    assign bus.in_ready = !v1 || !v2 || bus.out_ready;
    assign load1        = bus.in_valid && bus.in_ready;
    assign load2        = v1 && (!v2 || bus.out_ready);

    // Stage 1 valid bit and operand classification registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            cls_a_q  <= CLS_ZERO;
            cls_b_q  <= CLS_ZERO;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            if (load1) begin
                v1       <= 1'b1;
                cls_a_q  <= classify(bus.a);
                cls_b_q  <= classify(bus.b);
                sign_a_q <= bus.a[W-1];
                sign_b_q <= bus.sel ^ bus.b[W-1];
            end else if (load2) begin
                v1 <= 1'b0;
            end
        end
    end

    // ---------------- stage 2 resolution ----------------
    logic         nan_a, nan_b, snan_any, inf_a, inf_b, zero_a, zero_b;
    logic [1:0]   exc_d;
    logic         res_zero_d;
    logic         invalid_d;
    logic [W-1:0] special_res_d;

    assign nan_a    = (cls_a_q == CLS_QNAN) || (cls_a_q == CLS_SNAN);
    assign nan_b    = (cls_b_q == CLS_QNAN) || (cls_b_q == CLS_SNAN);
    assign snan_any = (cls_a_q == CLS_SNAN) || (cls_b_q == CLS_SNAN);
    assign inf_a    = (cls_a_q == CLS_INF);
    assign inf_b    = (cls_b_q == CLS_INF);
    assign zero_a   = (cls_a_q == CLS_ZERO);
    assign zero_b   = (cls_b_q == CLS_ZERO);

    // Priority case split: NaN, then INF combinations, then signed zero.
    // Subnormals fall through with normals as ordinary numbers.
    always_comb begin
        exc_d         = EXC_NUM;
        res_zero_d    = 1'b0;
        invalid_d     = 1'b0;
        special_res_d = '0;
        if (nan_a || nan_b) begin
            exc_d         = EXC_NAN;
            invalid_d     = snan_any;
            special_res_d = QNAN_VAL;
        end else if (inf_a && inf_b) begin
            if (sign_a_q == sign_b_q) begin
                exc_d         = sign_a_q ? EXC_NINF : EXC_INF;
                special_res_d = inf_val(sign_a_q);
            end else begin
                // inf - inf has no meaningful result
                exc_d         = EXC_NAN;
                invalid_d     = 1'b1;
                special_res_d = QNAN_VAL;
            end
        end else if (inf_a) begin
            exc_d         = sign_a_q ? EXC_NINF : EXC_INF;
            special_res_d = inf_val(sign_a_q);
        end else if (inf_b) begin
            exc_d         = sign_b_q ? EXC_NINF : EXC_INF;
            special_res_d = inf_val(sign_b_q);
        end else if (zero_a && zero_b) begin
            // round-to-nearest sign rule: -0 only when both addends are -0
            res_zero_d    = 1'b1;
            special_res_d = {(sign_a_q && sign_b_q), {(W-1){1'b0}}};
        end
    end

    // Stage 2 valid bit and result registers; results hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2            <= 1'b0;
            op_q          <= 2'b00;
            exc_q         <= EXC_NUM;
            res_zero_q    <= 1'b0;
            invalid_q     <= 1'b0;
            special_res_q <= '0;
        end else begin
            if (load2) begin
                v2            <= 1'b1;
                op_q          <= {sign_a_q, sign_b_q};
                exc_q         <= exc_d;
                res_zero_q    <= res_zero_d;
                invalid_q     <= invalid_d;
                special_res_q <= special_res_d;
            end else if (bus.out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = v2;
    assign bus.op          = op_q;
    assign bus.exc         = exc_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.invalid     = invalid_q;
    assign bus.special_res = special_res_q;

`ifdef FP_EXC_STICKY_EN
    logic flag_q;

    // Sticky invalid: set by an accepted invalid result, set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flag_q <= 1'b0;
        else if (v2 && bus.out_ready && invalid_q)
            flag_q <= 1'b1;
        else if (bus.flag_clr)
            flag_q <= 1'b0;
    end

    assign bus.flag_invalid = flag_q;
`else
    logic flag_clr_unused;

    assign flag_clr_unused  = bus.flag_clr;
    assign bus.flag_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_fp_addsub_except_pipe.sv
// Bench for fp_addsub_except_pipe (FP32 configuration). Directed vectors with
// hand-computed expectations; a driver pushes the expected response when the
// input handshake occurs and a monitor pops/compares on each output handshake.
module tb_fp_addsub_except_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;
    localparam int PW    = 2 + 2 + 1 + 1 + W;

`ifdef FP_EXC_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic clk;
    logic rst;

    fp_addsub_except_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_addsub_except_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_out    = 0;

    logic [PW-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(input logic [1:0] op, input logic [1:0] exc,
                                         input logic rz, input logic inv,
                                         input logic [W-1:0] res);
        return {op, exc, rz, inv, res};
    endfunction

    function automatic logic [PW-1:0] dut_pk();
        return {bus.op, bus.exc, bus.res_zero, bus.invalid, bus.special_res};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic [PW-1:0] e);
        int   n;
        logic got;
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.sel      = ts;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (got) begin
            exp_q.push_back(e);
            n_acc++;
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: a=%h b=%h not accepted", ta, tb_v);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, PW'(exp_q.size()), PW'(0));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_valid"}, PW'(bus.out_valid), PW'(1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          stall_prev = 1'b0;
    logic [PW-1:0] stall_snap;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && bus.out_valid)
                check("hold_stable", dut_pk(), stall_snap);
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h expected none", dut_pk());
                end else begin
                    check("result", dut_pk(), exp_q.pop_front());
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_snap = dut_pk();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = 1'b0;
        bus.out_ready = 1'b1;
        bus.flag_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", dut_pk(), '0);
        check("reset_out_valid", PW'(bus.out_valid), PW'(0));
        check("reset_in_ready", PW'(bus.in_ready), PW'(1));
        check("reset_flag", PW'(bus.flag_invalid), PW'(0));
        rst = 1'b0;
        tick();

        // plain numbers: nothing special
        send(32'h3F800000, 32'h40000000, 1'b0, pk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0));
        wait_drain("num");
        check("flag_after_valid", PW'(bus.flag_invalid), PW'(0));

        // directed special-case vectors, issued back-to-back
        send(32'h7F800000, 32'h7F800000, 1'b1, pk(2'b01, 2'b11, 1'b0, 1'b1, 32'h7FC00000));
        send(32'h7F800000, 32'h7F800000, 1'b0, pk(2'b00, 2'b01, 1'b0, 1'b0, 32'h7F800000));
        send(32'hFF800000, 32'h3F800000, 1'b0, pk(2'b10, 2'b10, 1'b0, 1'b0, 32'hFF800000));
        send(32'h7F800001, 32'h00000000, 1'b0, pk(2'b00, 2'b11, 1'b0, 1'b1, 32'h7FC00000));
        send(32'h7FC00000, 32'h00000000, 1'b0, pk(2'b00, 2'b11, 1'b0, 1'b0, 32'h7FC00000));
        send(32'h80000000, 32'h80000000, 1'b0, pk(2'b11, 2'b00, 1'b1, 1'b0, 32'h80000000));
        send(32'h80000000, 32'h80000000, 1'b1, pk(2'b10, 2'b00, 1'b1, 1'b0, 32'h00000000));
        send(32'h80000000, 32'h00000000, 1'b1, pk(2'b11, 2'b00, 1'b1, 1'b0, 32'h80000000));
        send(32'h00000001, 32'h3F800000, 1'b1, pk(2'b01, 2'b00, 1'b0, 1'b0, 32'h0));
        send(32'h00000000, 32'h3F800000, 1'b0, pk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0));
        send(32'hFF800000, 32'hFF800000, 1'b1, pk(2'b10, 2'b11, 1'b0, 1'b1, 32'h7FC00000));
        send(32'h7F800000, 32'hFF800000, 1'b1, pk(2'b00, 2'b01, 1'b0, 1'b0, 32'h7F800000));
        send(32'h7F800000, 32'hFFC00000, 1'b0, pk(2'b01, 2'b11, 1'b0, 1'b0, 32'h7FC00000));
        send(32'hFF800001, 32'h7F800000, 1'b0, pk(2'b10, 2'b11, 1'b0, 1'b1, 32'h7FC00000));
        send(32'h40000000, 32'h7F800000, 1'b1, pk(2'b01, 2'b10, 1'b0, 1'b0, 32'hFF800000));
        wait_drain("vectors");
        check("flag_set", PW'(bus.flag_invalid), PW'(STICKY));

        // sticky flag survives a later valid result
        send(32'h3F800000, 32'h3F800000, 1'b0, pk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0));
        wait_drain("hold");
        check("flag_hold", PW'(bus.flag_invalid), PW'(STICKY));

        // clear alone
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check("flag_clr", PW'(bus.flag_invalid), PW'(0));

        // clear coincident with an invalid handshake: set wins
        bus.out_ready = 1'b0;
        send(32'h7F800001, 32'h3F800000, 1'b0, pk(2'b00, 2'b11, 1'b0, 1'b1, 32'h7FC00000));
        wait_valid("setclr");
        bus.out_ready = 1'b1;
        bus.flag_clr  = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check("flag_set_wins", PW'(bus.flag_invalid), PW'(STICKY));
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check("flag_clr2", PW'(bus.flag_invalid), PW'(0));
        wait_drain("setclr");

        // backpressure: only two pairs fit while the output is stalled
        bus.out_ready = 1'b0;
        base  = n_acc;
        n_out = 0;
        fork
            begin
                send(32'h7F800000, 32'h3F800000, 1'b0, pk(2'b00, 2'b01, 1'b0, 1'b0, 32'h7F800000));
                send(32'h80000000, 32'h80000000, 1'b0, pk(2'b11, 2'b00, 1'b1, 1'b0, 32'h80000000));
                send(32'h7FC00000, 32'h7FC00000, 1'b0, pk(2'b00, 2'b11, 1'b0, 1'b0, 32'h7FC00000));
            end
        join_none
        repeat (6) tick();
        check("bp_accepted", PW'(n_acc - base), PW'(2));
        check("bp_in_ready", PW'(bus.in_ready), PW'(0));
        check("bp_out_valid", PW'(bus.out_valid), PW'(1));
        bus.out_ready = 1'b1;
        wait fork;
        wait_drain("bp");
        check("bp_count", PW'(n_out), PW'(3));

        // reset mid-stream discards pipeline contents
        bus.out_ready = 1'b0;
        send(32'h7F800000, 32'h7F800000, 1'b1, pk(2'b01, 2'b11, 1'b0, 1'b1, 32'h7FC00000));
        send(32'h3F800000, 32'h40000000, 1'b0, pk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", PW'(bus.out_valid), PW'(0));
        check("rst_in_ready", PW'(bus.in_ready), PW'(1));
        check("rst_outputs", dut_pk(), '0);
        exp_q.delete();
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        n_out         = 0;
        repeat (6) tick();
        check("post_rst_silent", PW'(n_out), PW'(0));

        // pipeline works again after reset
        send(32'hFF800000, 32'h3F800000, 1'b0, pk(2'b10, 2'b10, 1'b0, 1'b0, 32'hFF800000));
        wait_drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_addsub_except_pipe.md
# fp_addsub_except_pipe

Parametrised, two-stage pipelined special-operand classifier and exception resolver for the floating-point add/subtract datapath. Accepts raw IEEE-754-style operands plus an add/sub select, classifies each operand (zero, subnormal, normal, infinity, quiet NaN, signalling NaN), and resolves the exception outcome together with a canonical special result. A valid/ready handshake on both sides lets it sit ahead of the mantissa alignment stage, with full backpressure support. It generalises the FP32-only combinational case split to arbitrary exponent/mantissa widths, and adds zero handling, sNaN detection, an invalid flag and pipelining.

## Interface
- EXP_W, 8, exponent field width (≥2)
- MAN_W, 23, mantissa field width (≥2); W = 1+EXP_W+MAN_W
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- sel  in  1  0 = A+B, 1 = A−B
- a, b  in  W  operands {sign, exp, man}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- op  out  2  {sign_a, sel^sign_b} (effective signs)
- exc  out  2  00 NUM, 01 INF, 10 NINF, 11 NaN
- res_zero  out  1  both operands zero; special_res holds the signed zero
- invalid  out  1  invalid-operation for this result
- special_res  out  W  canonical result when exc≠00 or res_zero=1, else 0
- flag_clr  in  1  clear sticky flag
- flag_invalid  out  1  sticky invalid flag

## Operation
- Stage 1 registers per-operand class and effective signs. Classes: exp=0 and man=0 → ZERO; exp=0 and man≠0 → SUB; exp all-ones and man=0 → INF; exp all-ones with man MSB=1 → QNAN; exp all-ones with man MSB=0 and man≠0 → SNAN; otherwise NORM.
- Stage 2 resolves in priority order:
  - Either operand NaN → exc=11, special_res = qNaN (sign 0, exp all-ones, man MSB only). invalid=1 iff either operand is SNAN.
  - Both INF, equal effective signs → exc=01 or 10 by that sign; special_res = ±INF.
  - Both INF, opposite effective signs → exc=11, invalid=1, qNaN.
  - Exactly one INF → exc by that operand's effective sign; special_res = ±INF.
  - Both ZERO → exc=00, res_zero=1, special_res = −0 iff both effective signs negative, else +0.
  - Otherwise → exc=00, res_zero=0, invalid=0, special_res=0.
- SUB is treated as a number (no flush).

## Timing
- Latency: 2 cycles from input handshake to out_valid. Throughput: 1 pair per cycle when out_ready=1.
- Each stage has a valid bit. A stage loads when it is empty or the next stage is loading or draining. in_ready = !v1 | !v2 | out_ready (combinational).
- While out_valid=1 and out_ready=0, all outputs hold stable. No pair is dropped or duplicated, and order is preserved.
- Reset (async, any cycle, including mid-transfer): v1=v2=0, out_valid=0, op=0, exc=0, res_zero=0, invalid=0, special_res=0, flag_invalid=0. Pipeline contents are discarded. in_ready=1 during and after reset.
- Data registers load only on stage enable; they carry no state when the stage is invalid.

## Configuration
- FP_EXC_STICKY_EN defined:
  - flag_invalid sets on the cycle after an output handshake (out_valid & out_ready) carrying invalid=1.
  - flag_clr=1 clears it on the next edge.
  - Simultaneous set and clear → set wins.
- FP_EXC_STICKY_EN undefined: flag_invalid is constant 0 and flag_clr is ignored. Ports are present in both builds.

## Test plan
- FP32, a=3F800000, b=40000000, sel=0 → two cycles later exc=00, res_zero=0, invalid=0, op=00, special_res=0.
- a=7F800000, b=7F800000, sel=1 → exc=11, invalid=1, special_res=7FC00000. The same pair with sel=0 → exc=01, special_res=7F800000.
- a=FF800000, b=3F800000, sel=0 → exc=10, special_res=FF800000. a=7F800001, b=0 → exc=11, invalid=1. a=7FC00000, b=0 → exc=11, invalid=0.
- a=80000000, b=80000000, sel=0 → res_zero=1, special_res=80000000. Same pair with sel=1 → special_res=00000000.
- Backpressure: out_ready=0, drive 3 valid pairs back-to-back → in_ready drops after 2 are accepted. Then release out_ready → all 3 results emerge in order, none lost. Assert rst mid-stream → out_valid=0 immediately and nothing emerges afterwards.
- With FP_EXC_STICKY_EN: an invalid result handshake → flag_invalid=1 and it holds across later valid results. flag_clr asserted in the same cycle as a new invalid handshake → flag stays 1. flag_clr alone → 0. Without the macro, flag_invalid stays 0 throughout.
